// File: rtl/drwire_rr_arbiter_pkg.sv
// Shared types and round-robin pick helper for the dual-rail channel arbiter.
package drwire_arb_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RTZ = 2'd2} arb_state_e;

   localparam int MAX_REQ = 16;
   localparam int GID_W   = $clog2(MAX_REQ);

   // First set bit of req scanning ptr, ptr+1, ... modulo n; 0 when nothing is set.
   function automatic logic [GID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [GID_W-1:0]   ptr,
                                                input int                 n);
      logic [GID_W-1:0] win;
      logic             found;
      int               idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && !found && req[idx[GID_W-1:0]]) begin
            win   = GID_W'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/drwire_rr_arbiter_if.sv
// Producer/consumer dual-rail bundle seen by the arbiter.
interface drwire_rr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ*WIDTH-1:0] in_t;
   logic [N_REQ*WIDTH-1:0] in_f;
   logic [N_REQ-1:0]       in_ack;
   logic [WIDTH-1:0]       out_t;
   logic [WIDTH-1:0]       out_f;
   logic                   out_ack;
   logic [GW-1:0]          grant_id;
   logic                   busy;
   logic                   err;

   modport master (output in_t, in_f, out_ack,
                   input  in_ack, out_t, out_f, grant_id, busy, err);
   modport slave  (input  in_t, in_f, out_ack,
                   output in_ack, out_t, out_f, grant_id, busy, err);
endinterface

// File: rtl/drwire_rr_arbiter_completion.sv
// Per-channel dual-rail DATA/NULL/illegal detector.
module drwire_completion #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] f,
   output logic             complete,
   output logic             is_null,
   output logic             illegal
);
   assign illegal  = |(t & f);
   assign complete = &(t ^ f);
   assign is_null  = ~|(t | f);
endmodule

// File: rtl/drwire_rr_arbiter.sv
// Round-robin sequencer sharing one four-phase dual-rail output among N_REQ producers.
module drwire_rr_arbiter
   import drwire_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic ck,
   input  logic reset,
   drwire_rr_arbiter_if.slave bus
);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_SEND = 2'(SEND);
   localparam logic [1:0] S_RTZ  = 2'(RTZ);

   logic [N_REQ-1:0] complete, is_null, illegal;
   logic [1:0]       state;
   logic [GW-1:0]    ptr, gid;
   logic [N_REQ-1:0] ack_q;
   logic [WIDTH-1:0] ot_q, of_q, win_t, win_f;
   logic             busy_q, err_q;
   logic [GID_W-1:0] pick;

   generate
      for (genvar i = 0; i < N_REQ; i++) begin : g_cmp
         drwire_completion #(.WIDTH(WIDTH)) u_cmp (
            .t        (bus.in_t[i*WIDTH +: WIDTH]),
            .f        (bus.in_f[i*WIDTH +: WIDTH]),
            .complete (complete[i]),
            .is_null  (is_null[i]),
            .illegal  (illegal[i])
         );
      end
   endgenerate

   assign pick = rr_pick(MAX_REQ'(complete), GID_W'(ptr), N_REQ);

   always_comb begin
      win_t = '0;
      win_f = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick == GID_W'(i)) begin
            win_t = bus.in_t[i*WIDTH +: WIDTH];
            win_f = bus.in_f[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         ptr    <= '0;
         gid    <= '0;
         ack_q  <= '0;
         ot_q   <= '0;
         of_q   <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         // A consumer ack with nothing outstanding is a protocol violation, not a grant.
         if (|illegal || (state == S_IDLE && bus.out_ack)) err_q <= 1'b1;
         case (state)
            S_IDLE: if (!bus.out_ack && |complete) begin
               ot_q   <= win_t;
               of_q   <= win_f;
               gid    <= GW'(pick);
               busy_q <= 1'b1;
               state  <= S_SEND;
            end
            S_SEND: if (bus.out_ack) begin
               ot_q  <= '0;
               of_q  <= '0;
               ack_q <= N_REQ'(1) << gid;
               state <= S_RTZ;
            end
            S_RTZ: if (!bus.out_ack && is_null[gid]) begin
               ack_q  <= '0;
               ptr    <= (gid == GW'(N_REQ-1)) ? '0 : gid + GW'(1);
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ack   = ack_q;
   assign bus.out_t    = ot_q;
   assign bus.out_f    = of_q;
   assign bus.grant_id = gid;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;

endmodule
